// File: rtl/lc3_int_pkg.sv
// rtl/lc3_int_pkg.sv - shared widths and FSM states for the LC-3 interrupt controller
package lc3_int_pkg;
   localparam int PRIO_W = 3;
   localparam int VEC_W  = 8;
   localparam int MAX_CH = 16;
   localparam int IDX_W  = $clog2(MAX_CH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      ACKED  = 2'd2
   } int_state_e;
endpackage

// File: rtl/lc3_int_prio_enc.sv
// rtl/lc3_int_prio_enc.sv - combinational arbiter: highest priority wins, lowest index breaks ties
module lc3_int_prio_enc
   import lc3_int_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]        elig,
   input  logic [PRIO_W*NUM_CH-1:0] prio,
   output logic                     win_valid,
   output logic [IDX_W-1:0]         win_idx,
   output logic [PRIO_W-1:0]        win_prio
);
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      win_prio  = '0;
      // Strict compare keeps the earlier (lower) index on a priority tie.
      for (int i = 0; i < NUM_CH; i++) begin
         if (elig[i] && (!win_valid || (prio[PRIO_W*i +: PRIO_W] > win_prio))) begin
            win_valid = 1'b1;
            win_idx   = IDX_W'(i);
            win_prio  = prio[PRIO_W*i +: PRIO_W];
         end
      end
   end
endmodule

// File: rtl/lc3_prio_int_ctrl.sv
// rtl/lc3_prio_int_ctrl.sv - LC-3 prioritized interrupt controller with registered outputs
// Edge-triggered channels (EDGE_MASK) are built only when LC3_INT_EDGE_EN is defined.
module lc3_prio_int_ctrl
   import lc3_int_pkg::*;
#(
   parameter int                NUM_CH    = 4,
   parameter logic [VEC_W-1:0]  VEC_BASE  = 8'h80,
   parameter logic [NUM_CH-1:0] EDGE_MASK = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        irq,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [PRIO_W*NUM_CH-1:0] ch_prio,
   input  logic [PRIO_W-1:0]        psr_prio,
   input  logic                     int_ack,
   output logic                     INT,
   output logic [VEC_W-1:0]         INTV,
   output logic [PRIO_W-1:0]        Int_Priority,
   output logic [NUM_CH-1:0]        pend
);
   int_state_e        state;
   logic [IDX_W-1:0]  lat_idx;
   logic [NUM_CH-1:0] elig, ack_clr, edge_set, edge_sel, pend_nxt;
   logic              lat_en, win_valid;
   logic [IDX_W-1:0]  win_idx;
   logic [PRIO_W-1:0] win_prio;

`ifdef LC3_INT_EDGE_EN
   logic [NUM_CH-1:0] irq_q;
   logic              armed;

   // armed stays low for the first cycle after reset so a request already high is not an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_q <= '0;
         armed <= 1'b0;
      end else begin
         irq_q <= irq;
         armed <= 1'b1;
      end
   end

   assign edge_sel = EDGE_MASK;
   assign edge_set = irq & ~irq_q & {NUM_CH{armed}};
`else
   logic unused_edge_mask;
   assign unused_edge_mask = ^EDGE_MASK;
   assign edge_sel = '0;
   assign edge_set = '0;
`endif

   always_comb begin
      elig     = '0;
      ack_clr  = '0;
      pend_nxt = '0;
      lat_en   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         elig[i]    = pend[i] && ch_en[i] && (ch_prio[PRIO_W*i +: PRIO_W] != '0);
         ack_clr[i] = (state == ASSERT) && int_ack && (lat_idx == IDX_W'(i));
         if (lat_idx == IDX_W'(i)) lat_en = ch_en[i];
         // A new edge in the ack cycle wins over the clear.
         pend_nxt[i] = edge_sel[i] ? (edge_set[i] || (pend[i] && !ack_clr[i])) : irq[i];
      end
   end

   lc3_int_prio_enc #(.NUM_CH(NUM_CH)) u_enc (
      .elig      (elig),
      .prio      (ch_prio),
      .win_valid (win_valid),
      .win_idx   (win_idx),
      .win_prio  (win_prio)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         INT          <= 1'b0;
         INTV         <= '0;
         Int_Priority <= '0;
         lat_idx      <= '0;
         pend         <= '0;
      end else begin
         pend <= pend_nxt;
         case (state)
            IDLE: begin
               if (win_valid && (win_prio > psr_prio)) begin
                  state        <= ASSERT;
                  INT          <= 1'b1;
                  lat_idx      <= win_idx;
                  INTV         <= VEC_BASE + VEC_W'(win_idx);
                  Int_Priority <= win_prio;
               end
            end
            ASSERT: begin
               if (int_ack) begin
                  state <= ACKED;
                  INT   <= 1'b0;
               end else if (!lat_en || (psr_prio >= Int_Priority)) begin
                  state <= IDLE;
                  INT   <= 1'b0;
               end
            end
            ACKED: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               INT   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lc3_prio_int_ctrl.sv
// tb/tb_lc3_prio_int_ctrl.sv - directed and randomized checks against a cycle-level reference model
module tb_lc3_prio_int_ctrl;
   localparam int N = 4;
`ifdef LC3_INT_EDGE_EN
   localparam logic [N-1:0] EM = 4'b0100;
`else
   localparam logic [N-1:0] EM = 4'b0000;
`endif
   localparam int M_IDLE = 0, M_ASSERT = 1, M_ACKED = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   irq, ch_en;
   logic [3*N-1:0] ch_prio;
   logic [2:0]     psr_prio;
   logic           int_ack;
   logic           INT;
   logic [7:0]     INTV;
   logic [2:0]     Int_Priority;
   logic [N-1:0]   pend;

   int errors = 0;
   int checks = 0;

   int m_st, m_idx, m_intv, m_prio;
   bit m_int, m_armed;
   bit m_pend [N];
   bit m_prev [N];

   lc3_prio_int_ctrl #(.NUM_CH(N), .VEC_BASE(8'h80), .EDGE_MASK(4'b0100)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .ch_en        (ch_en),
      .ch_prio      (ch_prio),
      .psr_prio     (psr_prio),
      .int_ack      (int_ack),
      .INT          (INT),
      .INTV         (INTV),
      .Int_Priority (Int_Priority),
      .pend         (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_int = 0; m_intv = 0; m_prio = 0; m_idx = 0; m_armed = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_prev[i] = 0;
      end
   endtask

   // Winner = eligible channel maximising prio*N + (N-1-index).
   task automatic model_clock();
      int best, score, bp;
      bit ack_now;
      bit np [N];
      best = -1; score = -1; bp = 0;
      for (int i = 0; i < N; i++) begin
         int p;
         p = int'(ch_prio[3*i +: 3]);
         if (m_pend[i] && ch_en[i] && p != 0 && (p * N + (N - 1 - i)) > score) begin
            score = p * N + (N - 1 - i);
            best  = i;
            bp    = p;
         end
      end
      ack_now = (m_st == M_ASSERT) && int_ack;
      for (int i = 0; i < N; i++) begin
         if (EM[i]) begin
            if (irq[i] && !m_prev[i] && m_armed) np[i] = 1;
            else if (ack_now && m_idx == i)      np[i] = 0;
            else                                 np[i] = m_pend[i];
         end else begin
            np[i] = irq[i];
         end
      end
      if (m_st == M_IDLE) begin
         if (best >= 0 && bp > int'(psr_prio)) begin
            m_st = M_ASSERT; m_int = 1; m_idx = best; m_prio = bp;
            m_intv = (128 + best) % 256;
         end
      end else if (m_st == M_ASSERT) begin
         if (int_ack) begin
            m_st = M_ACKED; m_int = 0;
         end else if (!ch_en[m_idx] || int'(psr_prio) >= m_prio) begin
            m_st = M_IDLE; m_int = 0;
         end
      end else begin
         m_st = M_IDLE;
      end
      for (int i = 0; i < N; i++) begin
         m_pend[i] = np[i];
         m_prev[i] = irq[i];
      end
      m_armed = 1;
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] mp;
      for (int i = 0; i < N; i++) mp[i] = m_pend[i];
      chk({tag, ".INT"},  32'(INT), 32'(m_int));
      chk({tag, ".INTV"}, 32'(INTV), 32'(m_intv));
      chk({tag, ".PRIO"}, 32'(Int_Priority), 32'(m_prio));
      chk({tag, ".pend"}, 32'(pend), 32'(mp));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; irq = '0; ch_en = '0; ch_prio = '0; psr_prio = '0; int_ack = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      @(posedge clk);
      #1 reset = 1'b1;
      ch_en   = 4'hF;
      ch_prio = {3'd3, 3'd6, 3'd6, 3'd4};
      tick("idle0");

      // ch0 level request: pend one edge later, INT the edge after that.
      irq = 4'b0001;
      tick("c25_pend");
      chk("c25_pend0", 32'(pend[0]), 32'd1);
      chk("c25_int_lo", 32'(INT), 32'd0);
      tick("c25_int");
      chk("c25_int", 32'(INT), 32'd1);
      chk("c25_intv", 32'(INTV), 32'h80);
      chk("c25_prio", 32'(Int_Priority), 32'd4);
      int_ack = 1'b1; irq = '0;
      tick("c25_ack");
      chk("c25_acked_int", 32'(INT), 32'd0);
      int_ack = 1'b0;
      tick("c25_idle");

      // Equal priority tie on ch1/ch2, then ch2 after ch1 goes away.
      irq = 4'b0110;
      tick("c26_pend");
      tick("c26_grant");
      chk("c26_intv1", 32'(INTV), 32'h81);
      int_ack = 1'b1; irq = 4'b0100;
      tick("c26_ack");
      int_ack = 1'b0;
      tick("c26_idle");
      tick("c26_regrant");
      chk("c26_int2", 32'(INT), 32'd1);
      chk("c26_intv2", 32'(INTV), 32'h82);
      int_ack = 1'b1; irq = '0;
      tick("c26_ack2");
      int_ack = 1'b0;
      tick("c26_idle2");

      // One-cycle pulse on ch2, new edge landing in the ack cycle.
      irq = 4'b0100;
      tick("c27_pulse");
      irq = '0;
      tick("c27_hold");
      tick("c27_wait");
      int_ack = 1'b1; irq = 4'b0100;
      tick("c27_ack");
      chk("c27_setwins", 32'(pend[2]), 32'd1);
      int_ack = 1'b0; irq = '0;
      tick("c27_idle");
      tick("c27_regrant");
`ifdef LC3_INT_EDGE_EN
      chk("c27_reint", 32'(INT), 32'd1);
      chk("c27_reintv", 32'(INTV), 32'h82);
`endif
      int_ack = 1'b1;
      tick("c27_ack2");
      int_ack = 1'b0;
      tick("c27_idle2");

      // PSR priority raised to the granted level withdraws the request.
      irq = 4'b1000;
      tick("c28_pend");
      tick("c28_int");
      chk("c28_int", 32'(INT), 32'd1);
      chk("c28_prio", 32'(Int_Priority), 32'd3);
      psr_prio = 3'd3;
      tick("c28_drop");
      chk("c28_drop_int", 32'(INT), 32'd0);
      chk("c28_pend", 32'(pend), 32'b1000);
      tick("c28_hold");
      psr_prio = 3'd0;
      tick("c28_re");

      // Asynchronous reset mid-ASSERT, requests held high across release.
      irq = 4'b1101;
      tick("c29_pre");
      reset = 1'b0;
      #1;
      model_reset();
      chk("c29_int", 32'(INT), 32'd0);
      chk("c29_intv", 32'(INTV), 32'h00);
      chk("c29_pend", 32'(pend), 32'd0);
      check_all("c29_async");
      reset = 1'b1; irq = 4'b0101;
      tick("c29_rel");
      chk("c29_pend0", 32'(pend[0]), 32'd1);
      tick("c29_grant");
      irq = '0;
      int_ack = 1'b1;
      tick("c29_ack");
      int_ack = 1'b0;
      tick("c29_idle");

      for (int c = 0; c < 600; c++) begin
         if (c % 64 == 0)
            for (int i = 0; i < N; i++) ch_prio[3*i +: 3] = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) irq = irq ^ 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ch_en = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) psr_prio = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
         int_ack = ($urandom_range(0, 2) == 0);
         tick($sformatf("rnd%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lc3_prio_int_ctrl.md
LC3_PRIO_INT_CTRL -- requirements
Module: lc3_prio_int_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of interrupt request channels, legal range 1..16.
REQ-002 Parameter VEC_BASE, default 8'h80: interrupt vector of channel 0; channel i vector = VEC_BASE + i, modulo 256.
REQ-003 Parameter EDGE_MASK, default all-zero [NUM_CH]: bit i = 1 makes channel i edge-triggered; 0 makes it level-sensitive.
REQ-004 Ports, in order: name, direction, width, meaning.
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq  in  NUM_CH  device request lines, synchronous to clk.
- ch_en  in  NUM_CH  per-channel enable mask.
- ch_prio  in  3*NUM_CH  static priority per channel; channel i uses bits [3i+2:3i].
- psr_prio  in  3  current PSR priority, from the datapath.
- int_ack  in  1  one-cycle pulse from the FSM when the vector is loaded.
- INT  out  1  interrupt request to the FSM.
- INTV  out  8  vector of the granted channel.
- Int_Priority  out  3  priority of the granted channel.
- pend  out  NUM_CH  pending-status register.

Function
REQ-005 Channel i is eligible when pend[i] = 1, ch_en[i] = 1 and its ch_prio is non-zero; priority 0 never interrupts.
REQ-006 Level channel: pend[i] is registered as irq[i] every cycle; int_ack does not clear it.
REQ-007 Edge channel: pend[i] sets one cycle after a 0->1 on irq[i] and clears on int_ack while i is the granted channel.
REQ-008 Simultaneous set and clear on the same channel in the same cycle: set wins, so pend stays 1.
REQ-009 Arbitration: the eligible channel with the highest ch_prio wins; on equal priority the lowest index wins.
REQ-010 States: IDLE, ASSERT, ACKED.
- IDLE -> ASSERT when a winner exists with prio > psr_prio.
- On that edge, the winner index, INTV and Int_Priority are latched.
REQ-011 In ASSERT, INT = 1 and INTV and Int_Priority are held stable. Preemption by higher-priority channels is not allowed until the state leaves ASSERT.
REQ-012 ASSERT -> ACKED on int_ack.
REQ-013 ASSERT -> IDLE without ack if ch_en of the latched channel drops, or if psr_prio >= the latched priority. INT falls on that same edge.
REQ-014 ACKED -> IDLE unconditionally after 1 cycle; INT = 0 in ACKED. This gives a level source one cycle to drop its request.
REQ-015 Latency: irq rising at edge n -> pend at n+1 -> INT = 1 at n+2.
REQ-016 int_ack is ignored in IDLE and ACKED.
REQ-017 All outputs are registered; no combinational path runs from any input to INT.

Reset
REQ-018 While reset = 0, asynchronously: state = IDLE, INT = 0, INTV = 8'h00, Int_Priority = 3'b000, pend = 0, edge-history flops = 0.
REQ-019 Reset asserted mid-ASSERT abandons the grant; no ack is expected after release.
REQ-020 An irq already high at reset release does not create an edge event; a level channel pends one cycle after release.

Configuration
REQ-021 With macro LC3_INT_EDGE_EN defined, EDGE_MASK is honoured and edge-detect flops are built.
REQ-022 Without LC3_INT_EDGE_EN, every channel is level-sensitive, EDGE_MASK is ignored and no edge flops exist.

Structure
REQ-023 Package lc3_int_pkg holds: state enum (IDLE/ASSERT/ACKED), PRIO_W = 3, VEC_W = 8, MAX_CH = 16.
REQ-024 Sub-module lc3_int_prio_enc holds the combinational arbiter (eligible mask + priorities -> winner valid, index, priority). It is instantiated once.

Verification
REQ-025 Scenario: NUM_CH=4, ch0 level, ch_prio0 = 4, psr_prio = 0, irq0 rises at edge 10 -> INT = 1 at edge 12, INTV = 8'h80, Int_Priority = 4.
REQ-026 Scenario: ch1 prio 6 and ch2 prio 6 pending together -> INTV = 8'h81; ack -> ACKED 1 cycle -> IDLE; after ch1 is cleared, ch2 is granted with INTV = 8'h82.
REQ-027 Scenario (LC3_INT_EDGE_EN, EDGE_MASK = 4'b0100): irq2 pulses 1 cycle -> pend[2] = 1 until int_ack. A new irq2 edge in the ack cycle leaves pend[2] = 1 and re-grants.
REQ-028 Scenario: in ASSERT with Int_Priority = 3, psr_prio set to 3 -> INT = 0 next edge, state IDLE, pend unchanged.
REQ-029 Scenario: reset driven low mid-ASSERT -> INT, INTV, pend = 0 immediately without a clock edge; after release with irq0 high, level pend0 = 1 one cycle later.
